// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: bursts of SCLK edges with CPOL/CPHA-decoded sample/shift strobes.
// Optional feature: define SCLK_GEN_PAUSE_EN to add the i_pause port that freezes a running burst.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_wr,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [CNT_W-1:0] i_cfg_len,
    input  logic             i_cfg_cpol,
    input  logic             i_cfg_cpha,
    input  logic             i_start_n,
`ifdef SCLK_GEN_PAUSE_EN
    input  logic             i_pause,
`endif
    output logic             o_ready,
    output logic             o_sclk,
    output logic             o_lead_edge,
    output logic             o_trail_edge,
    output logic             o_sample,
    output logic             o_shift,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [CNT_W-1:0] BIT_ONE  = 1;
    localparam logic [CNT_W:0]   EDGE_ONE = 1;
    localparam logic [CNT_W-1:0] LEN_RST  = 8;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic             sclk_q, sclk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;

    logic             pause_w;
    logic             tick_w;
    logic             lead_w;
    logic             trail_w;
    logic [CNT_W:0]   edge_last_w;
    logic             is_last_w;

`ifdef SCLK_GEN_PAUSE_EN
    assign pause_w = i_pause;
`else
    assign pause_w = 1'b0;
`endif

    // Edge counter holds completed edges, so an even count means the next edge is a leading one.
    assign edge_last_w = {len_q, 1'b0} - EDGE_ONE;
    assign is_last_w   = (edge_q == edge_last_w);
    assign tick_w      = (state_q == ST_RUN) && !pause_w && (len_q != '0)
                         && (cnt_q == div_q - DIV_ONE);
    assign lead_w      = tick_w && !edge_q[0];
    assign trail_w     = tick_w && edge_q[0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        bits_d  = bits_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        len_d   = len_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        case (state_q)
            ST_IDLE: begin
                sclk_d = cpol_q;
                if (i_cfg_wr) begin
                    div_d  = (i_cfg_div == '0) ? DIV_ONE : i_cfg_div;
                    len_d  = i_cfg_len;
                    cpol_d = i_cfg_cpol;
                    cpha_d = i_cfg_cpha;
                    sclk_d = i_cfg_cpol;
                end else if (!i_start_n) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    edge_d  = '0;
                    bits_d  = '0;
                end
            end
            ST_RUN: begin
                if (!pause_w) begin
                    if (len_q == '0) begin
                        state_d = ST_DONE;
                    end else if (tick_w) begin
                        cnt_d  = '0;
                        sclk_d = ~sclk_q;
                        edge_d = edge_q + EDGE_ONE;
                        if (trail_w) begin
                            bits_d = bits_q + BIT_ONE;
                        end
                        if (is_last_w) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_ONE;
                    end
                end
            end
            ST_DONE: begin
                sclk_d  = cpol_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            bits_q  <= '0;
            sclk_q  <= 1'b0;
            div_q   <= DIV_ONE;
            len_q   <= LEN_RST;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            bits_q  <= bits_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            len_q   <= len_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
        end
    end

    assign o_ready      = (state_q == ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_sclk       = sclk_q;
    assign o_bit_count  = bits_q;
    assign o_lead_edge  = lead_w;
    assign o_trail_edge = trail_w;
    // With CPHA=0 the final trailing edge ends the burst, so no shift is issued there.
    assign o_sample     = cpha_q ? trail_w : lead_w;
    assign o_shift      = cpha_q ? lead_w : (trail_w && !is_last_w);

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: cycle-accurate arithmetic reference model plus literal timing checks.
module tb_spi_sclk_gen;

    logic       clk = 1'b0;
    logic       rst_n, cfg_wr, cpol, cpha, start_n;
    logic       pause = 1'b0;
    logic [7:0] div;
    logic [5:0] len;
    logic       o_ready, o_sclk, o_lead, o_trail, o_sample, o_shift, o_done;
    logic [5:0] o_bits;

    always #5 clk = ~clk;

    spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_cfg_wr(cfg_wr),
        .i_cfg_div(div),
        .i_cfg_len(len),
        .i_cfg_cpol(cpol),
        .i_cfg_cpha(cpha),
        .i_start_n(start_n),
`ifdef SCLK_GEN_PAUSE_EN
        .i_pause(pause),
`endif
        .o_ready(o_ready),
        .o_sclk(o_sclk),
        .o_lead_edge(o_lead),
        .o_trail_edge(o_trail),
        .o_sample(o_sample),
        .o_shift(o_shift),
        .o_bit_count(o_bits),
        .o_done(o_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 done; m_act counts un-paused run cycles.
    int m_div, m_len, m_cpol, m_cpha, m_phase, m_act, m_bits;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_div = 1; m_len = 8; m_cpol = 0; m_cpha = 0;
            m_phase = 0; m_act = 0; m_bits = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (cfg_wr) begin
                        m_div  = (div == 0) ? 1 : int'(div);
                        m_len  = int'(len);
                        m_cpol = int'(cpol);
                        m_cpha = int'(cpha);
                    end else if (!start_n) begin
                        m_phase = 1; m_act = 0;
                    end
                end
                1: begin
                    if (!pause) begin
                        m_act++;
                        if (m_len == 0 || m_act == 2 * m_len * m_div) m_phase = 2;
                    end
                end
                default: begin
                    m_phase = 0; m_bits = m_len;
                end
            endcase
        end
    end

    // Observation log used by the literal timing checks.
    int ev_done, ev_sample, ev_shift, ev_edges, ev_fall, ev_first_shift, ev_last_sample;
    logic prev_sclk = 1'b0;

    task automatic clear_log();
        ev_done = -1; ev_sample = 0; ev_shift = 0; ev_edges = 0;
        ev_fall = -1; ev_first_shift = -1; ev_last_sample = -1;
    endtask

    int e_ready, e_sclk, e_bits, e_done, e_lead, e_trail, e_sample, e_shift, r, k, edges;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            e_ready = 0; e_done = 0; e_lead = 0; e_trail = 0; e_sample = 0; e_shift = 0; k = 0;
            case (m_phase)
                0: begin
                    e_ready = 1; e_sclk = m_cpol; e_bits = m_bits;
                end
                1: begin
                    r = m_act + 1;
                    edges = m_act / m_div;
                    e_sclk = m_cpol ^ (edges % 2);
                    e_bits = edges / 2;
                    if (!pause && m_len > 0 && (r % m_div) == 0) begin
                        k = r / m_div;
                        if (k % 2 == 1) e_lead = 1; else e_trail = 1;
                    end
                    e_sample = m_cpha ? e_trail : e_lead;
                    e_shift  = m_cpha ? e_lead : int'(e_trail == 1 && k != 2 * m_len);
                end
                default: begin
                    e_done = 1; e_sclk = m_cpol; e_bits = m_len;
                end
            endcase
            chk("ready", int'(o_ready), e_ready);
            chk("sclk", int'(o_sclk), e_sclk);
            chk("bit_count", int'(o_bits), e_bits);
            chk("done", int'(o_done), e_done);
            chk("lead", int'(o_lead), e_lead);
            chk("trail", int'(o_trail), e_trail);
            chk("sample", int'(o_sample), e_sample);
            chk("shift", int'(o_shift), e_shift);
            if (o_done) ev_done = cyc;
            if (o_sample) begin ev_sample++; ev_last_sample = cyc; end
            if (o_shift) begin
                ev_shift++;
                if (ev_first_shift < 0) ev_first_shift = cyc;
            end
            if (o_lead || o_trail) ev_edges++;
            if (prev_sclk && !o_sclk && ev_fall < 0) ev_fall = cyc;
            prev_sclk = o_sclk;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input int d, input int l, input int cp, input int ch);
        cfg_wr = 1'b1; div = 8'(d); len = 6'(l); cpol = 1'(cp); cpha = 1'(ch);
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic start_burst(output int t);
        clear_log();
        start_n = 1'b0;
        t = cyc;
        step();
        start_n = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (o_ready) break;
            step();
        end
        if (i == bound) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle cyc=%0d got=timeout exp=ready", cyc);
        end
    endtask

    int t0;

    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; start_n = 1'b1; cpol = 1'b0; cpha = 1'b0;
        div = 8'd0; len = 6'd0;
        clear_log();
        step(); step();
        rst_n = 1'b1;
        step();
        chk("rst_ready", int'(o_ready), 1);
        chk("rst_sclk", int'(o_sclk), 0);
        chk("rst_bits", int'(o_bits), 0);

        // Reset defaults: div=1, len=8.
        start_burst(t0);
        wait_idle(200);
        chk("def_ready_at", cyc - t0, 18);
        chk("def_done_at", ev_done - t0, 17);
        chk("def_edges", ev_edges, 16);
        chk("def_bits", int'(o_bits), 8);

        do_cfg(3, 4, 1, 0);
        chk("cpol_idle", int'(o_sclk), 1);
        start_burst(t0);
        wait_idle(200);
        chk("m0_first_fall", ev_fall - t0, 4);
        chk("m0_samples", ev_sample, 4);
        chk("m0_shifts", ev_shift, 3);
        chk("m0_done_at", ev_done - t0, 25);

        do_cfg(2, 2, 0, 1);
        start_burst(t0);
        wait_idle(200);
        chk("m1_first_shift", ev_first_shift - t0, 2);
        chk("m1_last_sample", ev_last_sample - t0, 8);
        chk("m1_shifts", ev_shift, 2);
        chk("m1_done_at", ev_done - t0, 9);

        // Config write and start while running are ignored.
        do_cfg(1, 3, 0, 0);
        start_burst(t0);
        step();
        cfg_wr = 1'b1; div = 8'd5; len = 6'd1; start_n = 1'b0;
        step();
        cfg_wr = 1'b0; start_n = 1'b1;
        wait_idle(200);
        chk("run_ignore_done_at", ev_done - t0, 7);

        // Simultaneous write and start: config latched, start dropped.
        cfg_wr = 1'b1; start_n = 1'b0; div = 8'd2; len = 6'd1; cpol = 1'b0; cpha = 1'b0;
        step();
        cfg_wr = 1'b0; start_n = 1'b1;
        chk("simul_idle", int'(o_ready), 1);
        start_burst(t0);
        wait_idle(200);
        chk("simul_done_at", ev_done - t0, 5);

        do_cfg(0, 3, 0, 0);
        start_burst(t0);
        wait_idle(200);
        chk("div0_done_at", ev_done - t0, 7);

        do_cfg(1, 0, 0, 0);
        start_burst(t0);
        wait_idle(200);
        chk("len0_done_at", ev_done - t0, 2);
        chk("len0_edges", ev_edges, 0);

        // Reset at edge 5 of a burst.
        do_cfg(1, 8, 0, 0);
        start_burst(t0);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_sclk", int'(o_sclk), 0);
        chk("mid_rst_ready", int'(o_ready), 1);
        chk("mid_rst_bits", int'(o_bits), 0);
        repeat (3) step();
        chk("mid_rst_no_done", ev_done, -1);

`ifdef SCLK_GEN_PAUSE_EN
        do_cfg(1, 8, 0, 0);
        start_burst(t0);
        repeat (3) step();
        pause = 1'b1;
        repeat (5) step();
        pause = 1'b0;
        wait_idle(200);
        chk("pause_done_at", ev_done - t0, 22);
`endif

        // Randomized bursts with noise on config/start (and pause when present).
        for (int it = 0; it < 40; it++) begin
            do_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            start_burst(t0);
            for (int c = 0; c < 400 && !o_ready; c++) begin
                cfg_wr  = ($urandom_range(0, 7) == 0);
                div     = 8'($urandom_range(0, 255));
                len     = 6'($urandom_range(0, 63));
                start_n = ($urandom_range(0, 3) != 0);
`ifdef SCLK_GEN_PAUSE_EN
                pause   = ($urandom_range(0, 3) == 0);
`endif
                step();
            end
            cfg_wr = 1'b0; start_n = 1'b1; pause = 1'b0;
            wait_idle(50);
            if (it % 8 == 7) step();
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
